fft_spec_buf: RTL



---
 rtl/fft_spec_pkg.sv | 47 ++++
 rtl/spec_pingpong_ram.sv | 50 +++++
 rtl/fft_spec_buf.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fft_spec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_spec_pkg
//  Purpose  : Shared sizes, FSM encoding and magnitude helpers for the
//             FFT spectrum buffer.
//  Revision : 1.0  initial release
// ============================================================================
package fft_spec_pkg;

    localparam int N_POINTS = 128;
    localparam int BINS     = 64;
    localparam int DATA_W   = 16;
    localparam int OUT_W    = 8;
    localparam int SHIFT    = 6;

    localparam int IDX_W    = $clog2(N_POINTS);
    localparam int ADDR_W   = $clog2(BINS);
    localparam int ABS_W    = DATA_W - 1;
    localparam int MAG_W    = DATA_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CAPT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // The most negative input has no positive twin; clamp it to full scale.
    function automatic logic [ABS_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
        logic [ABS_W-1:0] r;
        if (x == {1'b1, {ABS_W{1'b0}}})
            r = {ABS_W{1'b1}};
        else if (x[DATA_W-1])
            r = ~x[ABS_W-1:0] + ABS_W'(1);
        else
            r = x[ABS_W-1:0];
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] sat_mag(input logic [MAG_W-1:0] mag);
        logic [MAG_W-1:0] sh;
        sh = mag >> SHIFT;
        if (|sh[MAG_W-1:OUT_W])
            return {OUT_W{1'b1}};
        return sh[OUT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spec_pingpong_ram.sv
`default_nettype none
// ============================================================================
//  Module   : spec_pingpong_ram
//  Purpose  : Two BINS x OUT_W banks; one is written while the other is shown.
//  Revision : 1.0  initial release
// ============================================================================
module spec_pingpong_ram
    import fft_spec_pkg::*;
(
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [OUT_W-1:0]  i_wdata,
    input  logic              i_swap,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [OUT_W-1:0]  o_rd_data,
    output logic              o_disp_valid
);

    logic [OUT_W-1:0] r_mem [2][BINS];
    logic             r_wr_bank;
    logic             r_disp_valid;
    logic [OUT_W-1:0] r_rd_data;

    always_ff @(posedge clk_50m) begin
        if (i_we)
            r_mem[r_wr_bank][i_waddr] <= i_wdata;
    end

    // The display bank is always the one not being written.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_wr_bank    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            if (i_swap) begin
                r_wr_bank    <= ~r_wr_bank;
                r_disp_valid <= 1'b1;
            end
            r_rd_data <= r_disp_valid ? r_mem[~r_wr_bank][i_rd_addr] : '0;
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_disp_valid = r_disp_valid;

endmodule
`default_nettype wire

// File: rtl/fft_spec_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fft_spec_buf
//  Purpose  : Frame checker, magnitude pipe and ping-pong bar store for the
//             LCD spectrum display.
//  Revision : 1.0  initial release
// ============================================================================
module fft_spec_buf
    import fft_spec_pkg::*;
(
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              src_valid,
    input  logic              src_sop,
    input  logic              src_eop,
    input  logic [DATA_W-1:0] src_real,
    input  logic [DATA_W-1:0] src_imag,
    output logic              src_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    input  logic              rd_done,
    output logic              frame_rdy,
    output logic [7:0]        drop_cnt
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_POINTS - 1);
    localparam logic [IDX_W-1:0] c_bins_idx = IDX_W'(BINS);
    localparam logic [IDX_W-1:0] c_one      = IDX_W'(1);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_drop_cnt;
    logic              r_done_lat;
    logic              r_frame_rdy;

    logic              r_s1_v;
    logic [IDX_W-1:0]  r_s1_idx;
    logic [ABS_W-1:0]  r_s1_re_abs;
    logic [ABS_W-1:0]  r_s1_im_abs;
    logic              r_s2_v;
    logic [IDX_W-1:0]  r_s2_idx;
    logic [MAG_W-1:0]  r_s2_mag;
    logic              r_s3_we;
    logic [ADDR_W-1:0] r_s3_addr;
    logic [OUT_W-1:0]  r_s3_data;

    logic              w_ready;
    logic              w_beat;
    logic              w_accept;
    logic [IDX_W-1:0]  w_beat_idx;
    logic              w_drop_evt;
    logic              w_drained;
    logic              w_disp_valid;
    logic              w_free;
    logic              w_swap;
    logic [ABS_W-1:0]  w_max;
    logic [ABS_W-1:0]  w_min;

    assign w_ready    = (r_state != ST_HOLD) && (r_state != ST_COMMIT);
    assign w_beat     = src_valid && w_ready;
    assign w_accept   = w_beat && ((r_state == ST_CAPT) || ((r_state == ST_IDLE) && src_sop));
    assign w_beat_idx = src_sop ? '0 : r_idx;
    assign w_drop_evt = w_beat && (r_state == ST_CAPT) &&
                        (src_sop || (src_eop != (r_idx == c_last_idx)));
    assign w_drained  = !r_s1_v && !r_s2_v && !r_s3_we;
    assign w_free     = !w_disp_valid || r_done_lat || rd_done;
    assign w_swap     = (((r_state == ST_COMMIT) && w_drained) || (r_state == ST_HOLD)) && w_free;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_drop_cnt  <= '0;
            r_done_lat  <= 1'b0;
            r_frame_rdy <= 1'b0;
        end else begin
            r_frame_rdy <= w_swap;

            if (w_swap)
                r_done_lat <= 1'b0;
            else if (rd_done)
                r_done_lat <= 1'b1;

            if (w_drop_evt && (r_drop_cnt != 8'hff))
                r_drop_cnt <= r_drop_cnt + 8'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_beat && src_sop) begin
                        r_idx   <= c_one;
                        r_state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (w_beat) begin
                        if (src_sop) begin
                            r_idx <= c_one;
                        end else if (r_idx == c_last_idx) begin
                            r_idx   <= '0;
                            r_state <= src_eop ? ST_COMMIT : ST_IDLE;
                        end else if (src_eop) begin
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + c_one;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (w_drained)
                        r_state <= w_free ? ST_IDLE : ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_free)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Alpha-max-plus-beta-min magnitude with beta = 1/2.
    assign w_max = (r_s1_re_abs >= r_s1_im_abs) ? r_s1_re_abs : r_s1_im_abs;
    assign w_min = (r_s1_re_abs >= r_s1_im_abs) ? r_s1_im_abs : r_s1_re_abs;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_s1_v      <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_re_abs <= '0;
            r_s1_im_abs <= '0;
            r_s2_v      <= 1'b0;
            r_s2_idx    <= '0;
            r_s2_mag    <= '0;
            r_s3_we     <= 1'b0;
            r_s3_addr   <= '0;
            r_s3_data   <= '0;
        end else begin
            r_s1_v      <= w_accept;
            r_s1_idx    <= w_beat_idx;
            r_s1_re_abs <= abs_sat(src_real);
            r_s1_im_abs <= abs_sat(src_imag);
            r_s2_v      <= r_s1_v;
            r_s2_idx    <= r_s1_idx;
            r_s2_mag    <= MAG_W'(w_max) + MAG_W'(w_min >> 1);
            r_s3_we     <= r_s2_v && (r_s2_idx < c_bins_idx);
            r_s3_addr   <= r_s2_idx[ADDR_W-1:0];
            r_s3_data   <= sat_mag(r_s2_mag);
        end
    end

    spec_pingpong_ram u_ram (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .i_we         (r_s3_we),
        .i_waddr      (r_s3_addr),
        .i_wdata      (r_s3_data),
        .i_swap       (w_swap),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_disp_valid (w_disp_valid)
    );

    assign src_ready = w_ready;
    assign frame_rdy = r_frame_rdy;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
